mips_decode_execute: RTL and testbench

Decode-and-execute slice of the five-stage MIPS pipeline. It combines the main control decoder (opcode to datapath control signals), the ALU control decoder (ALUOp + funct to a 4-bit ALU operation code) and the 32-bit ALU. It sits between the ID/EX boundary and the EX/MEM register. Control outputs are combinational; the ALU result and zero flag are registered once.

---
 rtl/mips_decode_execute_pkg.sv | 48 ++++
 rtl/mips_decode_execute_if.sv | 33 +++
 rtl/mips_decode_execute_alu.sv | 30 +++
 rtl/mips_decode_execute.sv | 99 +++++++++
 tb/tb_mips_decode_execute.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/mips_decode_execute_pkg.sv
// Shared constants and types for the MIPS decode/execute slice.
package mips_pkg;

  // Opcodes (instruction[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // R-type funct field (instruction[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_NOR = 6'b100111;

  // ALUOp from the main decoder to the ALU control decoder
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_RSVD  = 2'b11
  } aluOp_e;

  // 4-bit ALU operation codes
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_INV = 4'b1111;

  // Main decoder output bundle, in datapath order
  typedef struct packed {
    logic   regDst;
    logic   aluSrc;
    logic   memToReg;
    logic   regWrite;
    logic   memRead;
    logic   memWrite;
    logic   branch;
    aluOp_e aluOp;
  } ctrl_t;

endpackage

// File: rtl/mips_decode_execute_if.sv
// Bus between the ID/EX boundary and the decode/execute slice.
interface mips_decode_execute_if #(
  parameter int WIDTH = 32
);
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic [WIDTH-1:0] imm_ext;
  logic             reg_dst;
  logic             branch;
  logic             mem_read;
  logic             mem_to_reg;
  logic             mem_write;
  logic             alu_src;
  logic             reg_write;
  logic [1:0]       alu_op;
  logic [3:0]       alu_ctl;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;

  modport master (
    output opcode, funct, rs_data, rt_data, imm_ext,
    input  reg_dst, branch, mem_read, mem_to_reg, mem_write, alu_src,
           reg_write, alu_op, alu_ctl, result_q, zero_q
  );

  modport slave (
    input  opcode, funct, rs_data, rt_data, imm_ext,
    output reg_dst, branch, mem_read, mem_to_reg, mem_write, alu_src,
           reg_write, alu_op, alu_ctl, result_q, zero_q
  );
endinterface

// File: rtl/mips_decode_execute_alu.sv
// Combinational WIDTH-bit ALU; undefined codes yield zero.
module mips_alu_core
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic        [3:0]       ctl,
  output logic signed [WIDTH-1:0] result,
  output logic                    zero
);

  // Operation select; add/sub wrap naturally at WIDTH bits
  always_comb begin
    result = '0;
    case (ctl)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, (a < b)};
      ALU_NOR: result = ~(a | b);
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/mips_decode_execute.sv
// Decode-and-execute slice: main control, ALU control, operand mux,
// ALU and a single result register feeding EX/MEM.
module mips_decode_execute
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic                 clk,
  input logic                 rst_n,
  mips_decode_execute_if.slave bus
);

  ctrl_t                   ctrl;
  logic [3:0]              aluCtl;
  logic signed [WIDTH-1:0] opA_p0;
  logic signed [WIDTH-1:0] opB_p0;
  logic signed [WIDTH-1:0] aluResult_p0;
  logic                    aluZero_p0;
  logic [WIDTH-1:0]        result_p1;
  logic                    zero_p1;

  // Main control decode; unknown opcodes leave every control low
  always_comb begin
    ctrl = '{default: '0, aluOp: ALUOP_ADD};
    case (bus.opcode)
      OP_RTYPE: ctrl = '{regDst: 1'b1, aluSrc: 1'b0, memToReg: 1'b0, regWrite: 1'b1,
                         memRead: 1'b0, memWrite: 1'b0, branch: 1'b0, aluOp: ALUOP_FUNCT};
      OP_LW:    ctrl = '{regDst: 1'b0, aluSrc: 1'b1, memToReg: 1'b1, regWrite: 1'b1,
                         memRead: 1'b1, memWrite: 1'b0, branch: 1'b0, aluOp: ALUOP_ADD};
      OP_SW:    ctrl = '{regDst: 1'b0, aluSrc: 1'b1, memToReg: 1'b0, regWrite: 1'b0,
                         memRead: 1'b0, memWrite: 1'b1, branch: 1'b0, aluOp: ALUOP_ADD};
      OP_BEQ:   ctrl = '{regDst: 1'b0, aluSrc: 1'b0, memToReg: 1'b0, regWrite: 1'b0,
                         memRead: 1'b0, memWrite: 1'b0, branch: 1'b1, aluOp: ALUOP_SUB};
      OP_ADDI:  ctrl = '{regDst: 1'b0, aluSrc: 1'b1, memToReg: 1'b0, regWrite: 1'b1,
                         memRead: 1'b0, memWrite: 1'b0, branch: 1'b0, aluOp: ALUOP_ADD};
      default:  ctrl = '{default: '0, aluOp: ALUOP_ADD};
    endcase
  end

  // ALU control decode; the reserved ALUOp behaves like add
  always_comb begin
    aluCtl = ALU_ADD;
    case (ctrl.aluOp)
      ALUOP_ADD:  aluCtl = ALU_ADD;
      ALUOP_SUB:  aluCtl = ALU_SUB;
      ALUOP_RSVD: aluCtl = ALU_ADD;
      ALUOP_FUNCT: begin
        case (bus.funct)
          FN_ADD:  aluCtl = ALU_ADD;
          FN_SUB:  aluCtl = ALU_SUB;
          FN_AND:  aluCtl = ALU_AND;
          FN_OR:   aluCtl = ALU_OR;
          FN_SLT:  aluCtl = ALU_SLT;
          FN_NOR:  aluCtl = ALU_NOR;
          default: aluCtl = ALU_INV;
        endcase
      end
      default:    aluCtl = ALU_ADD;
    endcase
  end

  assign bus.reg_dst    = ctrl.regDst;
  assign bus.alu_src    = ctrl.aluSrc;
  assign bus.mem_to_reg = ctrl.memToReg;
  assign bus.reg_write  = ctrl.regWrite;
  assign bus.mem_read   = ctrl.memRead;
  assign bus.mem_write  = ctrl.memWrite;
  assign bus.branch     = ctrl.branch;
  assign bus.alu_op     = ctrl.aluOp;
  assign bus.alu_ctl    = aluCtl;

  // ---- stage p0: operand select and ALU ----
  assign opA_p0 = bus.rs_data;
  assign opB_p0 = ctrl.aluSrc ? bus.imm_ext : bus.rt_data;

  mips_alu_core #(.WIDTH(WIDTH)) u_alu (
    .a      (opA_p0),
    .b      (opB_p0),
    .ctl    (aluCtl),
    .result (aluResult_p0),
    .zero   (aluZero_p0)
  );

  // ---- stage p1: EX/MEM result register ----
  // Capture result and zero flag; reset clears them asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_p1 <= '0;
      zero_p1   <= 1'b0;
    end else begin
      result_p1 <= aluResult_p0;
      zero_p1   <= aluZero_p0;
    end
  end

  assign bus.result_q = result_p1;
  assign bus.zero_q   = zero_p1;

endmodule

// File: tb/tb_mips_decode_execute.sv
// Directed self-checking bench for mips_decode_execute.
module tb_mips_decode_execute;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  mips_decode_execute_if #(.WIDTH(32)) bus ();

  mips_decode_execute #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Controls packed as {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op}
  logic [8:0] ctlVec;
  assign ctlVec = {bus.reg_dst, bus.alu_src, bus.mem_to_reg, bus.reg_write,
                   bus.mem_read, bus.mem_write, bus.branch, bus.alu_op};

  task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
    bus.opcode  = op;
    bus.funct   = fn;
    bus.rs_data = a;
    bus.rt_data = b;
    bus.imm_ext = imm;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(6'b000000, 6'b100000, 32'd5, 32'd3, 32'd0);
    tick();
    checks++;
    if (bus.result_q !== 32'd0) begin errors++; $display("FAIL reset_result got=%h exp=%h", bus.result_q, 32'd0); end
    checks++;
    if (bus.zero_q !== 1'b0) begin errors++; $display("FAIL reset_zero got=%b exp=%b", bus.zero_q, 1'b0); end
    checks++;
    if (ctlVec !== 9'b1_0_0_1_0_0_0_10) begin errors++; $display("FAIL reset_ctl got=%b exp=%b", ctlVec, 9'b100100010); end
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.result_q !== 32'd8) begin errors++; $display("FAIL release_result got=%h exp=%h", bus.result_q, 32'd8); end
    // Asynchronous assertion between edges clears the register at once
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.result_q !== 32'd0) begin errors++; $display("FAIL async_reset got=%h exp=%h", bus.result_q, 32'd0); end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_rtype();
    logic [5:0]  fns [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010};
    logic [3:0]  ctls[6] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100, 4'b0111};
    logic [31:0] res [6] = '{32'h16, 32'h2, 32'h8, 32'hE, 32'hFFFFFFF1, 32'h0};
    for (int i = 0; i < 6; i++) begin
      drive(6'b000000, fns[i], 32'h0000000C, 32'h0000000A, 32'h00000100);
      checks++;
      if (bus.alu_ctl !== ctls[i]) begin errors++; $display("FAIL rtype_ctl[%0d] got=%b exp=%b", i, bus.alu_ctl, ctls[i]); end
      checks++;
      if (ctlVec !== 9'b100100010) begin errors++; $display("FAIL rtype_dec[%0d] got=%b exp=%b", i, ctlVec, 9'b100100010); end
      tick();
      checks++;
      if (bus.result_q !== res[i]) begin errors++; $display("FAIL rtype_res[%0d] got=%h exp=%h", i, bus.result_q, res[i]); end
    end
  endtask

  task automatic test_slt_wrap();
    drive(6'b000000, 6'b101010, 32'hFFFFFFFF, 32'h1, 32'h0);
    tick();
    checks++;
    if (bus.result_q !== 32'd1) begin errors++; $display("FAIL slt_neg got=%h exp=%h", bus.result_q, 32'd1); end
    drive(6'b000000, 6'b101010, 32'h1, 32'hFFFFFFFF, 32'h0);
    tick();
    checks++;
    if (bus.result_q !== 32'd0) begin errors++; $display("FAIL slt_pos got=%h exp=%h", bus.result_q, 32'd0); end
    drive(6'b000000, 6'b100000, 32'hFFFFFFFF, 32'h1, 32'h0);
    tick();
    checks++;
    if (bus.result_q !== 32'd0) begin errors++; $display("FAIL wrap_res got=%h exp=%h", bus.result_q, 32'd0); end
    checks++;
    if (bus.zero_q !== 1'b1) begin errors++; $display("FAIL wrap_zero got=%b exp=%b", bus.zero_q, 1'b1); end
  endtask

  task automatic test_mem_imm();
    drive(6'b100011, 6'b000000, 32'h100, 32'h5, 32'h10);
    checks++;
    if (ctlVec !== 9'b0_1_1_1_1_0_0_00) begin errors++; $display("FAIL lw_ctl got=%b exp=%b", ctlVec, 9'b011110000); end
    checks++;
    if (bus.alu_ctl !== 4'b0010) begin errors++; $display("FAIL lw_aluctl got=%b exp=%b", bus.alu_ctl, 4'b0010); end
    tick();
    checks++;
    if (bus.result_q !== 32'h110) begin errors++; $display("FAIL lw_res got=%h exp=%h", bus.result_q, 32'h110); end
    drive(6'b101011, 6'b000000, 32'h200, 32'h3, 32'h8);
    checks++;
    if (ctlVec !== 9'b0_1_0_0_0_1_0_00) begin errors++; $display("FAIL sw_ctl got=%b exp=%b", ctlVec, 9'b010001000); end
    tick();
    checks++;
    if (bus.result_q !== 32'h208) begin errors++; $display("FAIL sw_res got=%h exp=%h", bus.result_q, 32'h208); end
    drive(6'b001000, 6'b000000, 32'd10, 32'h55, 32'hFFFFFFFD);
    checks++;
    if (ctlVec !== 9'b0_1_0_1_0_0_0_00) begin errors++; $display("FAIL addi_ctl got=%b exp=%b", ctlVec, 9'b010100000); end
    tick();
    checks++;
    if (bus.result_q !== 32'd7) begin errors++; $display("FAIL addi_res got=%h exp=%h", bus.result_q, 32'd7); end
  endtask

  task automatic test_beq();
    drive(6'b000100, 6'b000000, 32'd7, 32'd7, 32'd0);
    checks++;
    if (ctlVec !== 9'b0_0_0_0_0_0_1_01) begin errors++; $display("FAIL beq_ctl got=%b exp=%b", ctlVec, 9'b000000101); end
    checks++;
    if (bus.alu_ctl !== 4'b0110) begin errors++; $display("FAIL beq_aluctl got=%b exp=%b", bus.alu_ctl, 4'b0110); end
    tick();
    checks++;
    if (bus.zero_q !== 1'b1) begin errors++; $display("FAIL beq_eq_zero got=%b exp=%b", bus.zero_q, 1'b1); end
    drive(6'b000100, 6'b000000, 32'd7, 32'd6, 32'd7);
    tick();
    checks++;
    if (bus.zero_q !== 1'b0) begin errors++; $display("FAIL beq_ne_zero got=%b exp=%b", bus.zero_q, 1'b0); end
    checks++;
    if (bus.result_q !== 32'd1) begin errors++; $display("FAIL beq_ne_res got=%h exp=%h", bus.result_q, 32'd1); end
  endtask

  task automatic test_illegal();
    drive(6'b111111, 6'b100010, 32'd9, 32'd4, 32'd1);
    checks++;
    if (ctlVec !== 9'd0) begin errors++; $display("FAIL illegal_ctl got=%b exp=%b", ctlVec, 9'd0); end
    checks++;
    if (bus.alu_ctl !== 4'b0010) begin errors++; $display("FAIL illegal_aluctl got=%b exp=%b", bus.alu_ctl, 4'b0010); end
    drive(6'b000000, 6'b000000, 32'd9, 32'd4, 32'd0);
    checks++;
    if (bus.alu_ctl !== 4'b1111) begin errors++; $display("FAIL badfunct_ctl got=%b exp=%b", bus.alu_ctl, 4'b1111); end
    tick();
    checks++;
    if (bus.result_q !== 32'd0) begin errors++; $display("FAIL badfunct_res got=%h exp=%h", bus.result_q, 32'd0); end
    checks++;
    if (bus.zero_q !== 1'b1) begin errors++; $display("FAIL badfunct_zero got=%b exp=%b", bus.zero_q, 1'b1); end
  endtask

  task automatic test_back_to_back();
    drive(6'b000000, 6'b100000, 32'd100, 32'd23, 32'd0);
    tick();
    drive(6'b000000, 6'b100010, 32'd50, 32'd8, 32'd0);
    checks++;
    if (bus.result_q !== 32'd123) begin errors++; $display("FAIL b2b_hold got=%h exp=%h", bus.result_q, 32'd123); end
    tick();
    drive(6'b000000, 6'b100101, 32'hF0, 32'h0F, 32'd0);
    checks++;
    if (bus.result_q !== 32'd42) begin errors++; $display("FAIL b2b_second got=%h exp=%h", bus.result_q, 32'd42); end
    tick();
    checks++;
    if (bus.result_q !== 32'hFF) begin errors++; $display("FAIL b2b_third got=%h exp=%h", bus.result_q, 32'hFF); end
  endtask

  initial begin
    bus.opcode  = '0;
    bus.funct   = '0;
    bus.rs_data = '0;
    bus.rt_data = '0;
    bus.imm_ext = '0;
    test_reset();
    test_rtype();
    test_slt_wrap();
    test_mem_imm();
    test_beq();
    test_illegal();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
